// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time over
// req/ack and hands each fetched instruction to the core over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic            drop_q, drop_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] instruction_q, instruction_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;

  logic [XLEN-1:0] target;
  logic            ack;

  assign target = redirect_pc & ALIGN_MASK;
  // An ack only means something while a request is actually outstanding.
  assign ack    = mem_ack && mem_req_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    drop_d        = drop_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_valid_d = instr_valid_q;
    instruction_d = instruction_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        mem_req_d  = 1'b1;
        mem_addr_d = pc_q;
      end
      S_FETCH: begin
        if (ack && (drop_q || redirect)) begin
          // Stale data: re-request at the newest redirect target.
          pc_d       = redirect ? target : pending_pc_q;
          drop_d     = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect ? target : pending_pc_q;
        end else if (ack) begin
          instruction_d = mem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + XLEN'(4);
          mem_req_d     = 1'b0;
          state_d       = S_HOLD;
        end else if (redirect) begin
          drop_d       = 1'b1;
          pending_pc_d = target;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          instruction_d = NOP_INSN;
          pc_d          = target;
          mem_req_d     = 1'b1;
          mem_addr_d    = target;
          state_d       = S_FETCH;
        end else if (instr_ready) begin
          fetch_count_d = fetch_count_q + XLEN'(1);
          instr_valid_d = 1'b0;
          instruction_d = NOP_INSN;
          mem_req_d     = 1'b1;
          mem_addr_d    = pc_q;
          state_d       = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_INIT;
      pending_pc_q  <= PC_INIT;
      drop_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= PC_INIT;
      instr_valid_q <= 1'b0;
      instruction_q <= NOP_INSN;
      instr_pc_q    <= PC_INIT;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      drop_q        <= drop_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_valid_q <= instr_valid_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instruction = instruction_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for directed corners, random traffic
// against a transaction-level model, and a PC wrap run near the top of memory.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] fetch_count;

  logic        w_reset;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_insn;
  logic [31:0] w_ipc;
  logic        w_vld;
  logic        w_ready;
  logic [31:0] w_count;

  int checks;
  int errors;

  fetch_unit u_dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clock(clock), .reset(w_reset),
    .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rdata(w_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .instruction(w_insn), .instr_pc(w_ipc), .instr_valid(w_vld),
    .instr_ready(w_ready), .fetch_count(w_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] insn;
    logic [31:0] ipc;
    logic [31:0] cnt;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  function automatic vec_t v(input logic rst, input logic ack, input logic [31:0] rdata,
                             input logic rdr, input logic [31:0] rpc, input logic rdy,
                             input logic req, input logic [31:0] addr, input logic vld,
                             input logic [31:0] insn, input logic [31:0] ipc,
                             input logic [31:0] cnt);
    vec_t r;
    r.rst = rst; r.ack = ack; r.rdata = rdata; r.rdr = rdr; r.rpc = rpc; r.rdy = rdy;
    r.req = req; r.addr = addr; r.vld = vld; r.insn = insn; r.ipc = ipc; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_row(input int idx, input logic [129:0] got, input logic [129:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL row%0d {req,addr,vld,insn,ipc,cnt}: got %h expected %h", idx, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] model_cnt;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    int          wait_cnt;
    int          idle;
    logic [31:0] waddrs [$];
    logic [31:0] wexp [3];

    checks = 0; errors = 0;
    clock = 1'b0;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; redirect = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0;
    w_reset = 1'b1; w_ack = 1'b0; w_rdata = '0; w_redirect = 1'b0; w_redirect_pc = '0;
    w_ready = 1'b1;

    //          rst ack rdata          rdr rpc          rdy  req addr          vld insn           ipc            cnt
    vecs[0]  = v(1, 0, 32'h0,          0, 32'h0,   0,   0, 32'h0,     0, 32'h13,    32'h0,   32'd0);
    vecs[1]  = v(0, 0, 32'h0,          0, 32'h0,   0,   1, 32'h0,     0, 32'h13,    32'h0,   32'd0);
    vecs[2]  = v(0, 1, 32'h100,        0, 32'h0,   1,   0, 32'h0,     1, 32'h100,   32'h0,   32'd0);
    vecs[3]  = v(0, 0, 32'h0,          0, 32'h0,   1,   1, 32'h4,     0, 32'h13,    32'h0,   32'd1);
    vecs[4]  = v(0, 1, 32'h104,        0, 32'h0,   1,   0, 32'h4,     1, 32'h104,   32'h4,   32'd1);
    vecs[5]  = v(0, 0, 32'h0,          0, 32'h0,   0,   0, 32'h4,     1, 32'h104,   32'h4,   32'd1);
    vecs[6]  = v(0, 1, 32'h55,         0, 32'h0,   0,   0, 32'h4,     1, 32'h104,   32'h4,   32'd1);
    vecs[7]  = v(0, 0, 32'h0,          0, 32'h0,   1,   1, 32'h8,     0, 32'h13,    32'h4,   32'd2);
    vecs[8]  = v(0, 0, 32'h0,          0, 32'h0,   1,   1, 32'h8,     0, 32'h13,    32'h4,   32'd2);
    vecs[9]  = v(0, 0, 32'h0,          1, 32'h203, 1,   1, 32'h8,     0, 32'h13,    32'h4,   32'd2);
    vecs[10] = v(0, 1, 32'hDEADBEEF,   0, 32'h0,   1,   1, 32'h200,   0, 32'h13,    32'h4,   32'd2);
    vecs[11] = v(0, 1, 32'h300,        0, 32'h0,   0,   0, 32'h200,   1, 32'h300,   32'h200, 32'd2);
    vecs[12] = v(0, 0, 32'h0,          1, 32'h40,  1,   1, 32'h40,    0, 32'h13,    32'h200, 32'd2);
    vecs[13] = v(0, 1, 32'hBAD,        1, 32'h80,  1,   1, 32'h80,    0, 32'h13,    32'h200, 32'd2);
    vecs[14] = v(0, 1, 32'h180,        0, 32'h0,   1,   0, 32'h80,    1, 32'h180,   32'h80,  32'd2);
    vecs[15] = v(0, 0, 32'h0,          0, 32'h0,   1,   1, 32'h84,    0, 32'h13,    32'h80,  32'd3);
    vecs[16] = v(1, 0, 32'h0,          0, 32'h0,   1,   0, 32'h0,     0, 32'h13,    32'h0,   32'd0);
    vecs[17] = v(0, 1, 32'h999,        0, 32'h0,   1,   1, 32'h0,     0, 32'h13,    32'h0,   32'd0);
    vecs[18] = v(0, 1, 32'h100,        0, 32'h0,   0,   0, 32'h0,     1, 32'h100,   32'h0,   32'd0);
    vecs[19] = v(0, 0, 32'h0,          0, 32'h0,   1,   1, 32'h4,     0, 32'h13,    32'h0,   32'd1);
    vecs[20] = v(0, 0, 32'h0,          1, 32'h500, 0,   1, 32'h4,     0, 32'h13,    32'h0,   32'd1);
    vecs[21] = v(0, 0, 32'h0,          1, 32'h606, 0,   1, 32'h4,     0, 32'h13,    32'h0,   32'd1);
    vecs[22] = v(0, 1, 32'h777,        0, 32'h0,   0,   1, 32'h604,   0, 32'h13,    32'h0,   32'd1);
    vecs[23] = v(0, 1, 32'h604,        0, 32'h0,   1,   0, 32'h604,   1, 32'h604,   32'h604, 32'd1);
    vecs[24] = v(0, 0, 32'h0,          0, 32'h0,   1,   1, 32'h608,   0, 32'h13,    32'h604, 32'd2);

    // Directed cycle table: inputs applied for one edge, outputs checked after it.
    @(negedge clock);
    for (int i = 0; i < NVEC; i++) begin
      reset = vecs[i].rst; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
      redirect = vecs[i].rdr; redirect_pc = vecs[i].rpc; instr_ready = vecs[i].rdy;
      @(negedge clock);
      chk_row(i, {mem_req, mem_addr, instr_valid, instruction, instr_pc, fetch_count},
                 {vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].insn, vecs[i].ipc, vecs[i].cnt});
    end

    // Random traffic: model tracks which PC must be delivered next and how many were taken.
    reset = 1'b1; mem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_pc = 32'h0; model_cnt = 32'h0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    wait_cnt = 0; idle = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      chk("overlap", 32'(instr_valid & mem_req), 32'h0);
      chk("align", 32'(mem_addr[1:0]), 32'h0);
      chk("count", fetch_count, model_cnt);
      if (prev_req && !prev_ack && mem_req) chk("addr_stable", mem_addr, prev_addr);

      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = (c > 4) && ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom & 32'h0000_FFFF;
      if (mem_req) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1; mem_rdata = mem_word(mem_addr); wait_cnt = $urandom_range(0, 3);
        end else begin
          mem_ack = 1'b0; mem_rdata = 32'hBADBAD00; wait_cnt--;
        end
      end else begin
        mem_ack = ($urandom_range(0, 4) == 0); mem_rdata = 32'hBADBAD00;
      end

      if (instr_valid && instr_ready && !redirect) begin
        chk("acc_pc", instr_pc, exp_pc);
        chk("acc_insn", instruction, mem_word(exp_pc));
        model_cnt = model_cnt + 32'd1;
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;

      idle = instr_valid ? 0 : idle + 1;
      if (idle > 200) begin
        checks++; errors++;
        $display("FAIL watchdog: got no instr_valid for %0d cycles expected under 200", idle);
        break;
      end
      prev_req = mem_req; prev_ack = mem_ack && mem_req; prev_addr = mem_addr;
    end
    chk("progress", 32'(model_cnt >= 32'd100), 32'h1);

    // PC wrap from RESET_PC = 0xFFFFFFF8 with zero-wait memory.
    reset = 1'b1; mem_ack = 1'b0; redirect = 1'b0;
    w_reset = 1'b1;
    @(negedge clock);
    w_reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (w_req) waddrs.push_back(w_addr);
      chk("w_overlap", 32'(w_vld & w_req), 32'h0);
      if (w_vld) chk("w_insn", w_insn, mem_word(w_ipc));
      w_ack = w_req; w_rdata = mem_word(w_addr);
    end
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    chk("w_nreq", 32'(waddrs.size() >= 3), 32'h1);
    for (int i = 0; i < 3 && i < waddrs.size(); i++) chk("w_addr", waddrs[i], wexp[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decoder/register/ALU datapath. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It presents each fetched instruction with its PC over a valid/ready handshake to the execute core, and accepts branch/jump redirects from the core. The design is single-issue and non-speculative, with at most one memory transaction outstanding.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; low 2 bits must be 0.
NOP_INSN, 32'h00000013, value driven on instruction while no valid instruction is held (addi x0,x0,0).

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mem_req  output  1  instruction memory read request (registered)
mem_addr  output  32  read address; word aligned; stable while mem_req=1 and no ack
mem_ack  input  1  one-cycle pulse; mem_rdata valid in the same cycle; ignored when mem_req=0
mem_rdata  input  32  read data
redirect  input  1  one-cycle pulse: next instruction comes from redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
instruction  output  32  fetched instruction to decoder (registered)
instr_pc  output  32  address of instruction (registered)
instr_valid  output  1  instruction/instr_pc valid
instr_ready  input  1  consumer accepts when instr_valid && instr_ready
fetch_count  output  32  number of instructions accepted by consumer; wraps

Behaviour:
- States: IDLE, FETCH, HOLD. Reset is synchronous and active-high, with priority over all other inputs at the clock edge.
- Reset values: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instruction=NOP_INSN, instr_pc=RESET_PC, fetch_count=0, drop=0.
- Reset asserted mid-transaction: the outstanding request is abandoned. A mem_ack arriving in or after the reset cycle while mem_req=0 is ignored.
- IDLE: unconditionally go to FETCH next cycle with mem_req=1 and mem_addr=pc. The first request appears in the 2nd cycle after reset deasserts.
- FETCH, no ack, no redirect: hold mem_req=1 and mem_addr unchanged.
- FETCH, redirect without ack:
  - The address must not change mid-transaction.
  - Set drop=1 and capture pending_pc = {redirect_pc[31:2],2'b00}. A later redirect overwrites pending_pc.
- FETCH, ack with drop=1, or ack with redirect in the same cycle:
  - Discard mem_rdata.
  - pc = the newest target: same-cycle redirect_pc takes priority over pending_pc.
  - Clear drop, stay FETCH, and next cycle issue a new request with mem_addr = new pc. mem_req stays 1.
- FETCH, ack, drop=0, no redirect:
  - instruction=mem_rdata, instr_pc=pc, instr_valid=1, pc=pc+4, mem_req=0, go HOLD.
- HOLD, redirect (priority over instr_ready):
  - instr_valid=0, instruction=NOP_INSN, pc=redirect target, go FETCH.
  - mem_req=1 and mem_addr=target next cycle.
  - The held instruction is not counted even if instr_ready=1.
- HOLD, instr_ready=1, no redirect:
  - Transfer completes this cycle and fetch_count increments.
  - instr_valid=0, instruction=NOP_INSN, go FETCH with mem_req=1 and mem_addr=pc.
- HOLD, instr_ready=0: instruction, instr_pc, and instr_valid hold stable indefinitely.
- Latency and throughput:
  - Ack at cycle N gives instr_valid=1 at N+1.
  - Acceptance at cycle M gives mem_req=1 at M+1.
  - With zero-wait memory and constant ready, one instruction is delivered per 2 cycles.
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000). fetch_count wraps modulo 2^32.
- Invariants: mem_addr[1:0]=0 always. instr_valid and mem_req are never both 1. Exactly one instruction is delivered per non-dropped ack.

Test Plan:
- Reset with RESET_PC=0; zero-wait memory returning word = addr+0x100; instr_ready=1 -> mem_req rises 2nd cycle after reset; consumer sees (pc,insn) = (0,0x100),(4,0x104),(8,0x108); fetch_count=3; instr_valid and mem_req never overlap.
- Memory acks 3 cycles late -> mem_addr is stable during the wait; instr_valid rises exactly 1 cycle after the ack.
- instr_ready=0 for 5 cycles while HOLD at pc 0x10 -> instruction/instr_pc are stable and mem_req=0; on ready, next mem_addr=0x14.
- Redirect to 0x203 during FETCH wait (ack 2 cycles later with 0xDEADBEEF) -> 0xDEADBEEF is never presented; next mem_addr=0x200; the delivered instr_pc is 0x200.
- Redirect to 0x40 in HOLD with instr_ready=1 at the same time -> fetch_count unchanged; instr_valid drops; next mem_addr=0x40. Redirect in the same cycle as an ack -> data dropped; re-request at the target.
- Run near RESET_PC=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. Reset asserted during an outstanding request -> mem_req=0 next cycle; a stray ack is ignored; fetch restarts at RESET_PC.
